// File: rtl/fetch_buf_if.sv
// rtl/fetch_buf_if.sv - fetch/decode handshake bundle for the instruction prefetch buffer
interface fetch_buf_if #(
    parameter int IW = 16,
    parameter int AW = 16,
    parameter int LW = 3
);
    logic [IW-1:0] instr_i;
    logic [AW-1:0] cnt_i;
    logic          vld_i;
    logic          rdy_o;
    logic [IW-1:0] instr_o;
    logic [AW-1:0] cnt_o;
    logic          vld_o;
    logic          rdy_i;
    logic          flush_i;
    logic [LW-1:0] level_o;
    logic [7:0]    flush_cnt_o;

    // Drives fetch data, decode ready and flush; observes buffer state.
    modport master (
        output instr_i, cnt_i, vld_i, rdy_i, flush_i,
        input  rdy_o, instr_o, cnt_o, vld_o, level_o, flush_cnt_o
    );

    modport slave (
        input  instr_i, cnt_i, vld_i, rdy_i, flush_i,
        output rdy_o, instr_o, cnt_o, vld_o, level_o, flush_cnt_o
    );
endinterface

// File: rtl/fetch_buf.sv
// rtl/fetch_buf.sv - instruction/PC prefetch FIFO with one-cycle flush
module fetch_buf #(
    parameter int DEPTH = 4,
    parameter int IW    = 16,
    parameter int AW    = 16
) (
    input  logic       clk_i,
    input  logic       rst,
    fetch_buf_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam int EW = IW + AW;

    logic [EW-1:0] mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [LW-1:0] count;
    logic [7:0]    flush_cnt;
    logic [EW-1:0] head;
    logic          full;
    logic          empty;
    logic          push;
    logic          pop;

    // Status comes from registered count only, so ready never depends on rdy_i.
    assign full  = (count == LW'(DEPTH));
    assign empty = (count == '0);
    assign push  = bus.vld_i & ~full & ~bus.flush_i;
    assign pop   = ~empty & bus.rdy_i & ~bus.flush_i;

    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (bus.flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + LW'(1);
                2'b01:   count <= count - LW'(1);
                default: count <= count;
            endcase
        end
    end

    // Only flushes that actually discard something are counted.
    always_ff @(posedge clk_i or posedge rst) begin
        if (rst) begin
            flush_cnt <= '0;
        end else if (bus.flush_i && !empty && flush_cnt != 8'hFF) begin
            flush_cnt <= flush_cnt + 8'd1;
        end
    end

    // Storage is never cleared; validity is tracked entirely by count.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem[wr_ptr] <= {bus.instr_i, bus.cnt_i};
        end
    end

    assign head = mem[rd_ptr];

    always_comb begin
        bus.instr_o = '0;
        bus.cnt_o   = '0;
        if (!empty) begin
            bus.instr_o = head[EW-1:AW];
            bus.cnt_o   = head[AW-1:0];
        end
    end

    assign bus.rdy_o       = ~full;
    assign bus.vld_o       = ~empty;
    assign bus.level_o     = count;
    assign bus.flush_cnt_o = flush_cnt;
endmodule

// File: tb/tb_fetch_buf.sv
// tb/tb_fetch_buf.sv - directed self-checking bench for fetch_buf
module tb_fetch_buf;
    localparam int DEPTH = 4;
    localparam int IW    = 16;
    localparam int AW    = 16;
    localparam int LW    = $clog2(DEPTH) + 1;

    logic clk_i = 1'b0;
    logic rst   = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    fetch_buf_if #(.IW(IW), .AW(AW), .LW(LW)) bus ();

    fetch_buf #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
        .clk_i (clk_i),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [15:0] pc,
                         input logic r, input logic f);
        bus.vld_i   = v;
        bus.instr_i = ins;
        bus.cnt_i   = pc;
        bus.rdy_i   = r;
        bus.flush_i = f;
    endtask

    initial begin
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        check("rst_vld", 32'(bus.vld_o), 32'd0);
        check("rst_rdy", 32'(bus.rdy_o), 32'd1);
        check("rst_level", 32'(bus.level_o), 32'd0);
        check("rst_instr", 32'(bus.instr_o), 32'd0);
        check("rst_cnt", 32'(bus.cnt_o), 32'd0);
        check("rst_fcnt", 32'(bus.flush_cnt_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // basic flow
        drive(1'b1, 16'h1234, 16'h0000, 1'b1, 1'b0);
        tick();
        check("basic_vld", 32'(bus.vld_o), 32'd1);
        check("basic_instr", 32'(bus.instr_o), 32'h1234);
        check("basic_cnt", 32'(bus.cnt_o), 32'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        tick();
        check("basic_vld_after", 32'(bus.vld_o), 32'd0);
        check("basic_instr_after", 32'(bus.instr_o), 32'd0);

        // fill to full, fifth push dropped
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 16'hA000 + 16'(k), 16'(k), 1'b0, 1'b0);
            tick();
            if (k == 3) begin
                check("full_level", 32'(bus.level_o), 32'd4);
                check("full_rdy", 32'(bus.rdy_o), 32'd0);
            end
        end
        check("full_level_5th", 32'(bus.level_o), 32'd4);
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("drain_instr%0d", k), 32'(bus.instr_o), 32'hA000 + 32'(k));
            check($sformatf("drain_cnt%0d", k), 32'(bus.cnt_o), 32'(k));
            tick();
        end
        check("drain_vld", 32'(bus.vld_o), 32'd0);
        check("drain_rdy", 32'(bus.rdy_o), 32'd1);

        // steady push/pop at level 2 across pointer wrap
        drive(1'b1, 16'h5100, 16'd100, 1'b0, 1'b0);
        tick();
        drive(1'b1, 16'h5101, 16'd101, 1'b0, 1'b0);
        tick();
        check("pp_level_init", 32'(bus.level_o), 32'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, 16'h5102 + 16'(i), 16'd102 + 16'(i), 1'b1, 1'b0);
            check($sformatf("pp_cnt%0d", i), 32'(bus.cnt_o), 32'd100 + 32'(i));
            tick();
            check($sformatf("pp_level%0d", i), 32'(bus.level_o), 32'd2);
        end
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b0);
        check("pp_tail0", 32'(bus.cnt_o), 32'd110);
        tick();
        check("pp_tail1", 32'(bus.cnt_o), 32'd111);
        check("pp_tail1_instr", 32'(bus.instr_o), 32'h510B);
        tick();
        check("pp_empty", 32'(bus.vld_o), 32'd0);

        // flush with 3 entries and a same-cycle push
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hC000 + 16'(k), 16'h0200 + 16'(k), 1'b0, 1'b0);
            tick();
        end
        check("fl_pre_level", 32'(bus.level_o), 32'd3);
        drive(1'b1, 16'hDEAD, 16'h0300, 1'b1, 1'b1);
        tick();
        check("fl_level", 32'(bus.level_o), 32'd0);
        check("fl_vld", 32'(bus.vld_o), 32'd0);
        check("fl_rdy", 32'(bus.rdy_o), 32'd1);
        check("fl_instr", 32'(bus.instr_o), 32'd0);
        check("fl_fcnt", 32'(bus.flush_cnt_o), 32'd1);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
        tick();
        check("fl_empty_fcnt", 32'(bus.flush_cnt_o), 32'd1);
        drive(1'b1, 16'hBEEF, 16'h0400, 1'b0, 1'b0);
        tick();
        check("fl_repush_vld", 32'(bus.vld_o), 32'd1);
        check("fl_repush_instr", 32'(bus.instr_o), 32'hBEEF);
        check("fl_repush_cnt", 32'(bus.cnt_o), 32'h0400);

        // async reset while full
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 16'hE000 + 16'(k), 16'(k), 1'b0, 1'b0);
            tick();
        end
        check("ar_pre_level", 32'(bus.level_o), 32'd4);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("ar_vld", 32'(bus.vld_o), 32'd0);
        check("ar_rdy", 32'(bus.rdy_o), 32'd1);
        check("ar_level", 32'(bus.level_o), 32'd0);
        check("ar_instr", 32'(bus.instr_o), 32'd0);
        check("ar_fcnt", 32'(bus.flush_cnt_o), 32'd0);
        tick();
        rst = 1'b0;
        tick();

        // flush counter saturation
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 16'h7000, 16'(i), 1'b0, 1'b0);
            tick();
            drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
            tick();
            if (i == 253) begin
                check("sat_254", 32'(bus.flush_cnt_o), 32'd254);
            end
            if (i == 254) begin
                check("sat_255", 32'(bus.flush_cnt_o), 32'd255);
            end
        end
        check("sat_hold", 32'(bus.flush_cnt_o), 32'hFF);
        check("sat_level", 32'(bus.level_o), 32'd0);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
